// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Lets the instruction-fetch port (I_*) and the data port (D_*) share one
// single-port synchronous SRAM (MEM_*). Only one transaction is in flight at
// a time. The data port normally has priority. If fetch loses STARVE_MAX
// arbitrations in a row, fetch wins the next one.
//
// Handshake (both ports): a requester raises REQ with its payload and holds
// both until it sees GNT high in the same cycle. GNT is combinational and is
// only offered in IDLE or RESP. After a grant the transaction runs
// CMD -> (WAIT x LAT-1) -> RESP. In RESP the owner sees a one-cycle RVALID
// with RDATA = MEM_DI. A requester may drop REQ before it sees GNT; this
// withdraws the request.
//
// Ports:
//   CLK, RSTn                        clock, synchronous active-low reset
//   I_REQ, I_ADDR                    fetch request, byte address
//   I_GNT, I_RVALID, I_RDATA         fetch grant, response pulse, data
//   D_REQ, D_WE, D_BE, D_ADDR,
//   D_WDATA                          data request and payload (word address)
//   D_GNT, D_RVALID, D_RDATA         data grant, response pulse, data
//   MEM_CSN, MEM_WEN, MEM_BE,
//   MEM_ADDR, MEM_DOUT, MEM_DI       SRAM macro interface (CSN/WEN active-low)
module unified_mem_arbiter #(
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4,
    parameter int AW         = 12
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          I_REQ,
    input  logic [11:0]   I_ADDR,
    output logic          I_GNT,
    output logic          I_RVALID,
    output logic [31:0]   I_RDATA,
    input  logic          D_REQ,
    input  logic          D_WE,
    input  logic [3:0]    D_BE,
    input  logic [AW-1:0] D_ADDR,
    input  logic [31:0]   D_WDATA,
    output logic          D_GNT,
    output logic          D_RVALID,
    output logic [31:0]   D_RDATA,
    output logic          MEM_CSN,
    output logic          MEM_WEN,
    output logic [3:0]    MEM_BE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [31:0]   MEM_DOUT,
    input  logic [31:0]   MEM_DI
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam int              LW       = $clog2(LAT + 1);
    localparam logic [LW-1:0]   LAT_LAST = LW'(LAT - 1);
    localparam int              CW       = $clog2(STARVE_MAX + 2);
    localparam logic [CW-1:0]   SMAX     = CW'(STARVE_MAX);
    localparam bit              STARVE_EN = (STARVE_MAX != 0);

    // FSM state, owner and counters. state is the observable FSM register.
    logic [1:0]    state;
    logic [1:0]    owner;
    logic [LW-1:0] lat_cnt;
    logic [CW-1:0] starve_cnt;

    logic          we_r;
    logic [3:0]    be_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   dout_r;
    logic [31:0]   i_rdata_q;
    logic [31:0]   d_rdata_q;

    logic arb_en;
    logic starve_sat;
    logic starve_flag;
    logic d_pri;
    logic d_win;
    logic i_win;

    // The fetch port addresses bytes; the memory addresses words.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^I_ADDR[1:0];

    always_comb begin
        arb_en      = RSTn && (state == S_IDLE || state == S_RESP);
        // The counter never goes above SMAX, so equality is the same as >=.
        starve_sat  = (starve_cnt == SMAX);
        starve_flag = STARVE_EN && starve_sat;
        d_pri       = D_REQ && !starve_flag;
        d_win       = arb_en && (d_pri || (D_REQ && !I_REQ));
        i_win       = arb_en && !d_pri && I_REQ;
    end

    assign I_GNT    = i_win;
    assign D_GNT    = d_win;

    assign MEM_CSN  = (state != S_CMD);
    // we_r is 0 for fetches, so fetch commands are always reads.
    assign MEM_WEN  = (state == S_CMD) ? ~we_r : 1'b1;
    assign MEM_BE   = be_r;
    assign MEM_ADDR = addr_r;
    assign MEM_DOUT = dout_r;

    assign I_RVALID = (state == S_RESP) && (owner == OWN_I);
    assign D_RVALID = (state == S_RESP) && (owner == OWN_D);
    assign I_RDATA  = I_RVALID ? MEM_DI : i_rdata_q;
    assign D_RDATA  = D_RVALID ? MEM_DI : d_rdata_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state      <= S_IDLE;
            owner      <= OWN_NONE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            we_r       <= 1'b0;
            be_r       <= 4'b0000;
            addr_r     <= '0;
            dout_r     <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            // Count fetch losses. Any grant to fetch, or fetch going quiet,
            // resets the count.
            if (I_REQ && d_win) begin
                if (!starve_sat) starve_cnt <= starve_cnt + 1'b1;
            end else if (!I_REQ || i_win) begin
                starve_cnt <= '0;
            end

            // Keep the last response so that RDATA holds when it is not valid.
            if (I_RVALID) i_rdata_q <= MEM_DI;
            if (D_RVALID) d_rdata_q <= MEM_DI;

            case (state)
                S_IDLE, S_RESP: begin
                    if (d_win) begin
                        state  <= S_CMD;
                        owner  <= OWN_D;
                        we_r   <= D_WE;
                        be_r   <= D_BE;
                        addr_r <= D_ADDR;
                        dout_r <= D_WDATA;
                    end else if (i_win) begin
                        state  <= S_CMD;
                        owner  <= OWN_I;
                        we_r   <= 1'b0;
                        be_r   <= 4'b1111;
                        addr_r <= AW'(I_ADDR[11:2]);
                        dout_r <= '0;
                    end else begin
                        state  <= S_IDLE;
                        owner  <= OWN_NONE;
                    end
                end
                S_CMD: begin
                    if (LAT > 1) begin
                        state   <= S_WAIT;
                        lat_cnt <= LW'(1);
                    end else begin
                        state   <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == LAT_LAST) state <= S_RESP;
                    else                     lat_cnt <= lat_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter. It has three instances that share
// the same stimulus:
//   u_a: LAT=1, STARVE_MAX=4
//   u_b: LAT=3, STARVE_MAX=4
//   u_c: LAT=1, STARVE_MAX=0
// Each instance has its own SRAM model, and each phase checks only the
// instance that phase targets.
module tb_unified_mem_arbiter;

    logic        CLK;
    logic        RSTn;
    logic        I_REQ;
    logic [11:0] I_ADDR;
    logic        D_REQ;
    logic        D_WE;
    logic [3:0]  D_BE;
    logic [11:0] D_ADDR;
    logic [31:0] D_WDATA;

    logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_mem_csn, a_mem_wen;
    logic [31:0] a_i_rdata, a_d_rdata, a_mem_dout, a_mem_di;
    logic [3:0]  a_mem_be;
    logic [11:0] a_mem_addr;
    logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_mem_csn, b_mem_wen;
    logic [31:0] b_i_rdata, b_d_rdata, b_mem_dout, b_mem_di;
    logic [3:0]  b_mem_be;
    logic [11:0] b_mem_addr;
    logic        c_i_gnt, c_i_rvalid, c_d_gnt, c_d_rvalid, c_mem_csn, c_mem_wen;
    logic [31:0] c_i_rdata, c_d_rdata, c_mem_dout, c_mem_di;
    logic [3:0]  c_mem_be;
    logic [11:0] c_mem_addr;

    int tests_run;
    int tests_failed;

    unified_mem_arbiter #(.LAT(1), .STARVE_MAX(4), .AW(12)) u_a (
        .CLK(CLK), .RSTn(RSTn),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(a_i_gnt), .I_RVALID(a_i_rvalid), .I_RDATA(a_i_rdata),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(a_d_gnt), .D_RVALID(a_d_rvalid), .D_RDATA(a_d_rdata),
        .MEM_CSN(a_mem_csn), .MEM_WEN(a_mem_wen), .MEM_BE(a_mem_be), .MEM_ADDR(a_mem_addr),
        .MEM_DOUT(a_mem_dout), .MEM_DI(a_mem_di)
    );

    unified_mem_arbiter #(.LAT(3), .STARVE_MAX(4), .AW(12)) u_b (
        .CLK(CLK), .RSTn(RSTn),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(b_i_gnt), .I_RVALID(b_i_rvalid), .I_RDATA(b_i_rdata),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(b_d_gnt), .D_RVALID(b_d_rvalid), .D_RDATA(b_d_rdata),
        .MEM_CSN(b_mem_csn), .MEM_WEN(b_mem_wen), .MEM_BE(b_mem_be), .MEM_ADDR(b_mem_addr),
        .MEM_DOUT(b_mem_dout), .MEM_DI(b_mem_di)
    );

    unified_mem_arbiter #(.LAT(1), .STARVE_MAX(0), .AW(12)) u_c (
        .CLK(CLK), .RSTn(RSTn),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(c_i_gnt), .I_RVALID(c_i_rvalid), .I_RDATA(c_i_rdata),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(c_d_gnt), .D_RVALID(c_d_rvalid), .D_RDATA(c_d_rdata),
        .MEM_CSN(c_mem_csn), .MEM_WEN(c_mem_wen), .MEM_BE(c_mem_be), .MEM_ADDR(c_mem_addr),
        .MEM_DOUT(c_mem_dout), .MEM_DI(c_mem_di)
    );

    // Clock and reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // SRAM models. A read latches data at the command edge, and u_b delays it
    // by two more stages, so MEM_DI is valid LAT cycles after the command.
    // Reset clears each memory and preloads a few known words.
    logic [31:0] mem_a [0:4095];
    logic [31:0] mem_b [0:4095];
    logic [31:0] mem_c [0:4095];
    logic [31:0] qa, qb0, qb1, qb2, qc;

    assign a_mem_di = qa;
    assign b_mem_di = qb2;
    assign c_mem_di = qc;

    always @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < 4096; i++) mem_a[i] = 32'h0;
            mem_a[12'h004] = 32'h00008067;
            qa <= 32'h0;
        end else if (!a_mem_csn) begin
            qa <= mem_a[a_mem_addr];
            if (!a_mem_wen)
                for (int k = 0; k < 4; k++)
                    if (a_mem_be[k]) mem_a[a_mem_addr][8*k +: 8] = a_mem_dout[8*k +: 8];
        end
    end

    always @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < 4096; i++) mem_b[i] = 32'h0;
            mem_b[12'h004] = 32'h00008067;
            mem_b[12'h050] = 32'hCAFEF00D;
            mem_b[12'h051] = 32'h12345678;
            qb0 <= 32'h0;
            qb1 <= 32'h0;
            qb2 <= 32'h0;
        end else begin
            if (!b_mem_csn) begin
                qb0 <= mem_b[b_mem_addr];
                if (!b_mem_wen)
                    for (int k = 0; k < 4; k++)
                        if (b_mem_be[k]) mem_b[b_mem_addr][8*k +: 8] = b_mem_dout[8*k +: 8];
            end
            qb1 <= qb0;
            qb2 <= qb1;
        end
    end

    always @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < 4096; i++) mem_c[i] = 32'h0;
            qc <= 32'h0;
        end else if (!c_mem_csn) begin
            qc <= mem_c[c_mem_addr];
            if (!c_mem_wen)
                for (int k = 0; k < 4; k++)
                    if (c_mem_be[k]) mem_c[c_mem_addr][8*k +: 8] = c_mem_dout[8*k +: 8];
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int  d_grants;
    logic exp_i;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RSTn    = 1'b0;
        I_REQ   = 1'b0;
        I_ADDR  = 12'h0;
        D_REQ   = 1'b0;
        D_WE    = 1'b0;
        D_BE    = 4'h0;
        D_ADDR  = 12'h0;
        D_WDATA = 32'h0;

        // Reset state. Both GNTs must stay low while RSTn is low, even with requests raised.
        step();
        step();
        D_REQ = 1'b1;
        I_REQ = 1'b1;
        #1;
        chk("rst_csn",    32'(a_mem_csn),  32'h1);
        chk("rst_wen",    32'(a_mem_wen),  32'h1);
        chk("rst_be",     32'(a_mem_be),   32'h0);
        chk("rst_addr",   32'(a_mem_addr), 32'h0);
        chk("rst_dout",   a_mem_dout,      32'h0);
        chk("rst_irv",    32'(a_i_rvalid), 32'h0);
        chk("rst_drv",    32'(a_d_rvalid), 32'h0);
        chk("rst_igntc",  32'(a_i_gnt),    32'h0);
        chk("rst_dgnt",   32'(a_d_gnt),    32'h0);
        D_REQ = 1'b0;
        I_REQ = 1'b0;
        RSTn  = 1'b1;
        step();

        // Fetch read at LAT=1
        I_REQ  = 1'b1;
        I_ADDR = 12'h010;
        #1;
        chk("f_igYes",    32'(a_i_gnt),    32'h1);
        chk("f_dgnt",     32'(a_d_gnt),    32'h0);
        step();
        I_REQ = 1'b0;
        #1;
        chk("f_csn",      32'(a_mem_csn),  32'h0);
        chk("f_addr",     32'(a_mem_addr), 32'h004);
        chk("f_be",       32'(a_mem_be),   32'hF);
        chk("f_wen",      32'(a_mem_wen),  32'h1);
        chk("f_dout",     a_mem_dout,      32'h0);
        step();
        #1;
        chk("f_rvalid",   32'(a_i_rvalid), 32'h1);
        chk("f_rdata",    a_i_rdata,       32'h00008067);
        chk("f_resp_csn", 32'(a_mem_csn),  32'h1);
        step();
        #1;
        chk("f_rv_low",   32'(a_i_rvalid), 32'h0);
        chk("f_hold",     a_i_rdata,       32'h00008067);
        chk("f_addrhold", 32'(a_mem_addr), 32'h004);

        // Data write, then a read-back granted in the write's RESP cycle
        D_REQ   = 1'b1;
        D_WE    = 1'b1;
        D_BE    = 4'b0011;
        D_ADDR  = 12'h020;
        D_WDATA = 32'hDEADBEEF;
        #1;
        chk("w_gnt",      32'(a_d_gnt),    32'h1);
        step();
        D_REQ = 1'b0;
        #1;
        chk("w_csn",      32'(a_mem_csn),  32'h0);
        chk("w_wen",      32'(a_mem_wen),  32'h0);
        chk("w_be",       32'(a_mem_be),   32'h3);
        chk("w_addr",     32'(a_mem_addr), 32'h020);
        chk("w_dout",     a_mem_dout,      32'hDEADBEEF);
        step();
        D_REQ = 1'b1;
        D_WE  = 1'b0;
        D_BE  = 4'hF;
        #1;
        chk("w_rvalid",   32'(a_d_rvalid), 32'h1);
        chk("w_irv",      32'(a_i_rvalid), 32'h0);
        chk("r_gnt_b2b",  32'(a_d_gnt),    32'h1);
        step();
        D_REQ = 1'b0;
        #1;
        chk("r_csn",      32'(a_mem_csn),  32'h0);
        chk("r_wen",      32'(a_mem_wen),  32'h1);
        step();
        #1;
        chk("r_rvalid",   32'(a_d_rvalid), 32'h1);
        chk("r_rdata",    a_d_rdata,       32'h0000BEEF);
        chk("r_ihold",    a_i_rdata,       32'h00008067);
        step();

        // Both held continuously: D,D,D,D,I,D,D,D,D,I with no idle gap
        I_REQ  = 1'b1;
        I_ADDR = 12'h010;
        D_REQ  = 1'b1;
        D_WE   = 1'b0;
        D_ADDR = 12'h030;
        for (int g = 0; g < 10; g++) begin
            exp_i = (g == 4) || (g == 9);
            #1;
            chk($sformatf("arb_i%0d", g), 32'(a_i_gnt), 32'(exp_i));
            chk($sformatf("arb_d%0d", g), 32'(a_d_gnt), 32'(!exp_i));
            step();
            #1;
            chk($sformatf("arb_cmd%0d", g), 32'(a_mem_csn), 32'h0);
            chk($sformatf("arb_nog%0d", g), 32'(a_i_gnt | a_d_gnt), 32'h0);
            step();
        end
        I_REQ = 1'b0;
        D_REQ = 1'b0;
        #1;
        chk("arb_last_irv", 32'(a_i_rvalid), 32'h1);
        chk("arb_last_ird", a_i_rdata,       32'h00008067);
        step();

        // LAT=3 read on u_b, with a second request raised in cycle 2
        RSTn = 1'b0;
        step();
        RSTn = 1'b1;
        step();
        D_REQ  = 1'b1;
        D_WE   = 1'b0;
        D_BE   = 4'hF;
        D_ADDR = 12'h050;
        #1;
        chk("l3_gnt0",    32'(b_d_gnt),    32'h1);
        step();
        D_REQ = 1'b0;
        #1;
        chk("l3_csn1",    32'(b_mem_csn),  32'h0);
        step();
        D_REQ  = 1'b1;
        D_ADDR = 12'h051;
        #1;
        chk("l3_csn2",    32'(b_mem_csn),  32'h1);
        chk("l3_gnt2",    32'(b_d_gnt),    32'h0);
        chk("l3_rv2",     32'(b_d_rvalid), 32'h0);
        step();
        #1;
        chk("l3_csn3",    32'(b_mem_csn),  32'h1);
        chk("l3_gnt3",    32'(b_d_gnt),    32'h0);
        chk("l3_rv3",     32'(b_d_rvalid), 32'h0);
        step();
        #1;
        chk("l3_rv4",     32'(b_d_rvalid), 32'h1);
        chk("l3_rd4",     b_d_rdata,       32'hCAFEF00D);
        chk("l3_gnt4",    32'(b_d_gnt),    32'h1);
        step();
        D_REQ = 1'b0;
        #1;
        chk("l3_rv5",     32'(b_d_rvalid), 32'h0);
        chk("l3_csn5",    32'(b_mem_csn),  32'h0);
        chk("l3_addr5",   32'(b_mem_addr), 32'h051);
        step();
        step();
        step();
        #1;
        chk("l3_rv8",     32'(b_d_rvalid), 32'h1);
        chk("l3_rd8",     b_d_rdata,       32'h12345678);
        step();

        // Reset during WAIT on u_b aborts the transaction
        D_REQ  = 1'b1;
        D_ADDR = 12'h050;
        #1;
        chk("ra_gnt",     32'(b_d_gnt),    32'h1);
        step();
        D_REQ = 1'b0;
        step();
        RSTn = 1'b0;
        #1;
        chk("ra_wait_csn", 32'(b_mem_csn), 32'h1);
        step();
        #1;
        chk("ra_csn",     32'(b_mem_csn),  32'h1);
        chk("ra_rv0",     32'(b_d_rvalid), 32'h0);
        RSTn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            #1;
            chk($sformatf("ra_drv%0d", c), 32'(b_d_rvalid), 32'h0);
            chk($sformatf("ra_irv%0d", c), 32'(b_i_rvalid), 32'h0);
        end
        I_REQ  = 1'b1;
        I_ADDR = 12'h010;
        #1;
        chk("ra_igntc",   32'(b_i_gnt),    32'h1);
        step();
        I_REQ = 1'b0;
        #1;
        chk("ra_f_csn",   32'(b_mem_csn),  32'h0);
        chk("ra_f_addr",  32'(b_mem_addr), 32'h004);
        chk("ra_f_be",    32'(b_mem_be),   32'hF);
        chk("ra_f_wen",   32'(b_mem_wen),  32'h1);
        step();
        step();
        step();
        #1;
        chk("ra_f_rv",    32'(b_i_rvalid), 32'h1);
        chk("ra_f_rd",    b_i_rdata,       32'h00008067);
        step();

        // STARVE_MAX=0 on u_c: fetch never wins while data requests
        RSTn = 1'b0;
        step();
        RSTn = 1'b1;
        step();
        I_REQ  = 1'b1;
        I_ADDR = 12'h010;
        D_REQ  = 1'b1;
        D_WE   = 1'b0;
        D_ADDR = 12'h000;
        d_grants = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk($sformatf("sm0_ignt%0d", c), 32'(c_i_gnt), 32'h0);
            if (c_d_gnt) d_grants++;
            step();
        end
        chk("sm0_dgrants", 32'(d_grants), 32'd10);
        I_REQ = 1'b0;
        D_REQ = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port 32-bit synchronous SRAM between the CPU instruction-fetch port and its data-access port.
- Sits between the core's I-MEM/D-MEM interfaces and a single unified memory macro.
- Uses a req/gnt/rvalid handshake with one outstanding transaction.
- Data port has fixed priority; a bounded-wait guard prevents fetch starvation.

Parameters:
- LAT, 1, memory read latency in cycles from command cycle to valid MEM_DI (LAT >= 1).
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins once (0 = pure data priority).
- AW, 12, memory word-address width.

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset
- I_REQ  in  1  fetch request; held with I_ADDR until I_GNT
- I_ADDR  in  12  fetch byte address; word = I_ADDR[11:2]
- I_GNT  out  1  fetch accepted this cycle (combinational)
- I_RVALID  out  1  one-cycle pulse; I_RDATA valid
- I_RDATA  out  32  fetch data
- D_REQ  in  1  data request; held with payload until D_GNT
- D_WE  in  1  1 = write
- D_BE  in  4  byte enables
- D_ADDR  in  AW  data word address
- D_WDATA  in  32  write data
- D_GNT  out  1  data accepted this cycle (combinational)
- D_RVALID  out  1  one-cycle pulse: read data valid or write complete
- D_RDATA  out  32  read data
- MEM_CSN  out  1  chip select, active-low
- MEM_WEN  out  1  write enable, active-low
- MEM_BE  out  4  byte enables
- MEM_ADDR  out  AW  word address
- MEM_DOUT  out  32  write data
- MEM_DI  in  32  read data

Behaviour:
- Reset: RSTn is synchronous, active-low; clock is CLK.
- While RSTn = 0, at the next edge:
  - state = IDLE, latency counter = 0, starvation counter = 0, owner = none.
  - MEM_CSN = 1, MEM_WEN = 1, MEM_BE = 0, MEM_ADDR = 0, MEM_DOUT = 0.
  - I_RVALID = D_RVALID = 0.
  - GNTs are forced to 0 while RSTn is low.
- Reset mid-transaction aborts it: no RVALID is ever issued for it; requesters re-request.
- States:
  - IDLE: no transaction.
  - CMD: memory command cycle.
  - WAIT: latency counting; skipped when LAT = 1.
  - RESP: RVALID cycle.
- Arbitration happens only in IDLE or RESP:
  - If D_REQ and not starve_flag, D wins.
  - Otherwise, if I_REQ, I wins.
  - Otherwise, if D_REQ, D wins.
  - starve_flag = (STARVE_MAX != 0) and (starve_cnt >= STARVE_MAX).
- Grant (cycle 0):
  - Exactly one GNT is high.
  - On the edge, the winner's address, BE, WE and WDATA are registered and the owner is recorded; next state = CMD.
- CMD (cycle 1):
  - MEM_CSN = 0; MEM_ADDR, MEM_BE, MEM_DOUT come from registers.
  - MEM_WEN = ~WE for data, 1 for fetch; fetch drives MEM_BE = 4'b1111 and MEM_DOUT = 0.
  - Next state = WAIT if LAT > 1, else RESP.
- WAIT: counter runs 1..LAT-1; MEM_CSN = 1; then RESP.
- RESP (cycle 1+LAT):
  - The owner's RVALID = 1 for exactly one cycle; the owner's RDATA = MEM_DI (combinational pass-through).
  - Non-owner RDATA holds its last value.
  - The write response is an acknowledgment only.
  - If a new grant occurs in this cycle, next state = CMD, giving back-to-back throughput of 1 transaction per LAT+1 cycles; otherwise IDLE.
- Outside CMD, MEM_CSN = 1, MEM_WEN = 1, and MEM_ADDR/BE/DOUT hold their values.
- Starvation counter (saturating at STARVE_MAX):
  - Increments on any arbitration cycle where I_REQ = 1 and D wins.
  - Clears when I is granted or I_REQ = 0.
- Simultaneous requests in IDLE with counters at 0: D is granted; I waits and I_GNT stays 0.
- A request asserted during CMD/WAIT is not granted until RESP. Requesters must hold it; dropping REQ before GNT is legal and simply withdraws it.

Test Plan:
- Reset, then I_REQ = 1 with I_ADDR = 12'h010 at LAT = 1 -> I_GNT in cycle 0; cycle 1 MEM_CSN = 0, MEM_ADDR = 12'h004, MEM_BE = 4'hF, MEM_WEN = 1; cycle 2 I_RVALID = 1 and I_RDATA = MEM_DI (model returns 32'h00008067).
- D write D_ADDR = 12'h020, D_BE = 4'b0011, D_WDATA = 32'hDEADBEEF -> cycle 1 MEM_WEN = 0, MEM_BE = 4'b0011, MEM_DOUT = 32'hDEADBEEF; D_RVALID pulses in cycle 2; a following read of 12'h020 returns 32'h0000BEEF (zero-initialised memory).
- I_REQ and D_REQ held together continuously, STARVE_MAX = 4, LAT = 1 -> grant order D, D, D, D, I, D, D, D, D, I; a new grant appears in every RESP cycle with no idle gap.
- LAT = 3 read -> MEM_CSN low only in cycle 1; D_RVALID exactly in cycle 4; a D_REQ raised in cycle 2 is granted in cycle 4.
- RSTn = 0 asserted in a WAIT cycle -> after the next edge MEM_CSN = 1, no RVALID pulse ever appears, and counters are 0; a request after release behaves as in the first scenario.
- STARVE_MAX = 0 with both requests held for 20 cycles -> I_GNT never asserts.
